emu_code_sched: RTL and testbench
=================================

// Module: emu_code_sched
// PURPOSE
//  Per-sample scheduler for the shared, channel-tagged emu_code_nco datapath.
//  Holds the per-channel config table (freq, ca_sel, enable), generating the sample
//  tick, issuing one dv_in strobe per channel slot and gathering returned code chips
//  into one N_CHAN-bit word per sample. Config changes apply only on sample boundaries.
// PARAMETERS
//  N_CHAN          8   number of satellite channels sharing the NCO
//  CLKS_PER_SAMPLE 64  clocks per output sample period
//  NCO_LAT         4   max clocks from nco_dv_in to matching nco_dv_out before timeout
// PORTS
//  clk            in  1       system clock
//  reset_n        in  1       asynchronous active-low reset
//  run            in  1       1 = generate samples; 0 = stop after current sample
//  cfg_we         in  1       write shadow entry cfg_chan
//  cfg_chan       in  CW      channel index, CW=$clog2(N_CHAN)
//  cfg_freq       in  32      phase increment for cfg_chan
//  cfg_ca_sel     in  6       PRN select for cfg_chan
//  cfg_en         in  1       channel enable for cfg_chan
//  cfg_commit     in  1       request shadow->active copy at next sample tick
//  commit_pend    out 1       commit requested, not yet applied
//  nco_dv_in      out 1       one-clock strobe to NCO
//  nco_chan       out CW      channel tag with nco_dv_in
//  nco_freq       out 32      active freq of nco_chan
//  nco_ca_sel     out 6       active ca_sel of nco_chan
//  nco_dv_out     in  1       NCO result valid
//  nco_chan_ret   in  CW      channel tag of returned result
//  nco_q          in  1       returned code chip
//  code_dv        out 1       one-clock strobe: code_bits/code_mask valid
//  code_bits      out N_CHAN  chip per channel (0 if not returned)
//  code_mask      out N_CHAN  1 = chip returned for that channel this sample
//  err_timeout    out 1       sticky: an issued channel did not return in NCO_LAT
//  busy           out 1       FSM not in IDLE
// BEHAVIOUR
//  - Reset (async assert, sync release): all outputs 0; FSM=IDLE; sample counter 0;
//    shadow and active tables cleared (all en=0, freq=0, ca_sel=0); commit_pend=0.
//  - Elaboration check: N_CHAN+NCO_LAT+2 <= CLKS_PER_SAMPLE, else $fatal.
//  - Sample counter: runs 0..CLKS_PER_SAMPLE-1 wrapping while FSM != IDLE; tick = count==0.
//  - FSM: IDLE -(run)-> TICK (counter forced to 0). TICK: if commit_pend copy
//    shadow->active, clear commit_pend; clear collection regs; -> ISSUE (next clk).
//    ISSUE: slot s=0..N_CHAN-1, one per clock; nco_chan=s, nco_freq/ca_sel=active[s];
//    nco_dv_in=active_en[s] (disabled slot still consumes its clock). After slot
//    N_CHAN-1 -> DRAIN. DRAIN: leave when returned==issued count, or NCO_LAT clocks
//    after last slot; on timeout set err_timeout. -> PUBLISH: code_dv=1 one clock,
//    then WAIT. WAIT: at count==CLKS_PER_SAMPLE-1 -> TICK if run else IDLE.
//  - Sample period exactly CLKS_PER_SAMPLE clocks TICK-to-TICK; code_dv fixed offset.
//  - Collection: nco_dv_out sets code_bits[nco_chan_ret]=nco_q, code_mask bit=1, in any
//    state except IDLE/TICK; tag of a channel not issued this sample is ignored
//    (no count); duplicate tag overwrites bit, counted once.
//  - code_bits/code_mask hold until next TICK clears them.
//  - cfg_we writes shadow only, any time; cfg_we and TICK copy same clk: copy uses old
//    shadow, the new write lands in shadow. cfg_commit with TICK-same-clk: pend
//    stays set for next tick. err_timeout cleared only by reset.
//  - run deassert mid-sample: sample completes incl. code_dv, then IDLE.
//  - Reset mid-sample: aborts immediately, no code_dv.
// TESTING
//  1 Reset/idle: reset_n=0 then 1, run=0 -> all outputs 0, busy=0, no nco_dv_in.
//  2 Single chan: ch3 freq=32'h27456789 ca_sel=3 en=1, commit, run; NCO model lat 2
//    -> one nco_dv_in/sample at tick+4 with chan=3, code_dv every 64 clks, mask=8'h08.
//  3 All 8 enabled, model returns out of order -> mask=8'hFF, bits match model,
//    8 consecutive dv_in strobes per sample.
//  4 Staged update: write ch3 freq=32'h12468ace mid-sample, commit -> nco_freq changes
//    only at next sample's slot 3; commit_pend drops at that tick.
//  5 Timeout: model drops ch5 -> err_timeout=1 sticky, mask bit5=0, period still 64.
//  6 run=0 mid-sample -> that sample's code_dv still fires, then busy=0; reset_n
//    pulse mid-ISSUE -> outputs 0 at once, no code_dv.

Source files
------------

// File: rtl/emu_code_sched.sv
// Per-sample scheduler for the shared, channel-tagged code NCO: owns the channel
// config tables, issues one NCO slot per channel each sample and gathers the chips.
module emu_code_sched #(
  parameter int N_CHAN          = 8,
  parameter int CLKS_PER_SAMPLE = 64,
  parameter int NCO_LAT         = 4,
  localparam int CW             = $clog2(N_CHAN)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              run,
  input  logic              cfg_we,
  input  logic [CW-1:0]     cfg_chan,
  input  logic [31:0]       cfg_freq,
  input  logic [5:0]        cfg_ca_sel,
  input  logic              cfg_en,
  input  logic              cfg_commit,
  output logic              commit_pend,
  output logic              nco_dv_in,
  output logic [CW-1:0]     nco_chan,
  output logic [31:0]       nco_freq,
  output logic [5:0]        nco_ca_sel,
  input  logic              nco_dv_out,
  input  logic [CW-1:0]     nco_chan_ret,
  input  logic              nco_q,
  output logic              code_dv,
  output logic [N_CHAN-1:0] code_bits,
  output logic [N_CHAN-1:0] code_mask,
  output logic              err_timeout,
  output logic              busy
);

  localparam int SW = $clog2(CLKS_PER_SAMPLE);
  localparam int DW = $clog2(NCO_LAT + 1);

  // The whole issue/drain/publish sequence must fit inside one sample period.
  if (N_CHAN + NCO_LAT + 2 > CLKS_PER_SAMPLE) begin : g_bad_params
    $fatal(1, "emu_code_sched: N_CHAN+NCO_LAT+2 exceeds CLKS_PER_SAMPLE");
  end

  typedef struct packed {
    logic [31:0] freq;
    logic [5:0]  ca_sel;
    logic        en;
  } cfg_t;

  typedef enum logic [2:0] {IDLE, TICK, ISSUE, DRAIN, PUBLISH, WAIT} state_t;

  state_t            state, state_nxt;
  cfg_t              shadow [N_CHAN];
  cfg_t              active [N_CHAN];
  logic [SW-1:0]     cnt;
  logic [CW-1:0]     slot;
  logic [DW-1:0]     drain_cnt;
  logic [N_CHAN-1:0] issued;
  logic [CW:0]       iss_cnt;
  logic [CW:0]       ret_cnt;
  logic              last_cnt, last_slot, collect, ret_hit, ret_new, all_ret, drain_to;

  assign last_cnt  = (cnt == SW'(CLKS_PER_SAMPLE - 1));
  assign last_slot = (slot == CW'(N_CHAN - 1));
  assign drain_to  = (drain_cnt == DW'(NCO_LAT - 1));
  assign busy      = (state != IDLE);

  // Returns are only accepted for channels issued in the current sample; a repeat
  // tag rewrites the chip but is not counted again.
  assign collect = (state != IDLE) && (state != TICK);
  assign ret_hit = collect && nco_dv_out && issued[nco_chan_ret];
  assign ret_new = ret_hit && !code_mask[nco_chan_ret];
  assign all_ret = ((ret_cnt + (CW+1)'(ret_new)) == iss_cnt);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_nxt  = state;
    nco_dv_in  = 1'b0;
    nco_chan   = '0;
    nco_freq   = '0;
    nco_ca_sel = '0;
    code_dv    = 1'b0;
    unique case (state)
      IDLE:    if (run) state_nxt = TICK;
      TICK:    state_nxt = ISSUE;
      ISSUE: begin
        nco_dv_in  = active[slot].en;
        nco_chan   = slot;
        nco_freq   = active[slot].freq;
        nco_ca_sel = active[slot].ca_sel;
        if (last_slot) state_nxt = DRAIN;
      end
      DRAIN:   if (all_ret || drain_to) state_nxt = PUBLISH;
      PUBLISH: begin
        code_dv   = 1'b1;
        state_nxt = last_cnt ? (run ? TICK : IDLE) : WAIT;
      end
      WAIT:    if (last_cnt) state_nxt = run ? TICK : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Config tables: shadow takes writes any time, active is loaded only at TICK.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the tables are small register arrays that must come up all-disabled,
      // so they are cleared by reset rather than left to power-up contents.
      for (int i = 0; i < N_CHAN; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      commit_pend <= 1'b0;
    end else begin
      // NOTE: non-blocking updates make a same-clock write land in shadow while
      // the copy below still takes the old shadow contents.
      if (cfg_we) shadow[cfg_chan] <= '{freq: cfg_freq, ca_sel: cfg_ca_sel, en: cfg_en};
      if (state == TICK && commit_pend) active <= shadow;
      if (cfg_commit)          commit_pend <= 1'b1;
      else if (state == TICK)  commit_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= '0;
      slot        <= '0;
      drain_cnt   <= '0;
      issued      <= '0;
      iss_cnt     <= '0;
      ret_cnt     <= '0;
      code_bits   <= '0;
      code_mask   <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (state == IDLE) cnt <= '0;
      else               cnt <= last_cnt ? '0 : cnt + 1'b1;

      drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
      if (state == DRAIN && drain_to && !all_ret) err_timeout <= 1'b1;

      if (state == TICK) begin
        slot      <= '0;
        issued    <= '0;
        iss_cnt   <= '0;
        ret_cnt   <= '0;
        code_bits <= '0;
        code_mask <= '0;
      end else begin
        if (state == ISSUE) begin
          slot <= last_slot ? '0 : slot + 1'b1;
          if (active[slot].en) begin
            issued[slot] <= 1'b1;
            iss_cnt      <= iss_cnt + 1'b1;
          end
        end
        if (ret_hit) begin
          code_bits[nco_chan_ret] <= nco_q;
          code_mask[nco_chan_ret] <= 1'b1;
        end
        if (ret_new) ret_cnt <= ret_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_emu_code_sched.sv
// Directed bench for emu_code_sched with a behavioural tagged NCO that returns
// results after a per-channel latency and can drop a channel.
module tb_emu_code_sched;

  localparam int N_CHAN = 8;
  localparam int CW     = 3;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              run = 1'b0;
  logic              cfg_we = 1'b0;
  logic [CW-1:0]     cfg_chan = '0;
  logic [31:0]       cfg_freq = '0;
  logic [5:0]        cfg_ca_sel = '0;
  logic              cfg_en = 1'b0;
  logic              cfg_commit = 1'b0;
  logic              commit_pend;
  logic              nco_dv_in;
  logic [CW-1:0]     nco_chan;
  logic [31:0]       nco_freq;
  logic [5:0]        nco_ca_sel;
  logic              nco_dv_out = 1'b0;
  logic [CW-1:0]     nco_chan_ret = '0;
  logic              nco_q = 1'b0;
  logic              code_dv;
  logic [N_CHAN-1:0] code_bits;
  logic [N_CHAN-1:0] code_mask;
  logic              err_timeout;
  logic              busy;

  emu_code_sched #(.N_CHAN(8), .CLKS_PER_SAMPLE(64), .NCO_LAT(4)) dut (
    .clk(clk), .reset_n(reset_n), .run(run),
    .cfg_we(cfg_we), .cfg_chan(cfg_chan), .cfg_freq(cfg_freq),
    .cfg_ca_sel(cfg_ca_sel), .cfg_en(cfg_en), .cfg_commit(cfg_commit),
    .commit_pend(commit_pend),
    .nco_dv_in(nco_dv_in), .nco_chan(nco_chan), .nco_freq(nco_freq),
    .nco_ca_sel(nco_ca_sel),
    .nco_dv_out(nco_dv_out), .nco_chan_ret(nco_chan_ret), .nco_q(nco_q),
    .code_dv(code_dv), .code_bits(code_bits), .code_mask(code_mask),
    .err_timeout(err_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // NCO model: return cycle = issue cycle + lat_tab[chan]; latencies chosen so
  // results come back out of order and never two in one clock.
  logic [7:0] chip_pat  = 8'hC9;
  logic [7:0] drop_mask = 8'h00;
  int lat_tab [N_CHAN] = '{4, 1, 1, 3, 1, 3, 1, 2};
  int due [N_CHAN];

  always @(negedge clk) begin
    nco_dv_out   <= 1'b0;
    nco_chan_ret <= '0;
    nco_q        <= 1'b0;
    if (!reset_n) begin
      for (int c = 0; c < N_CHAN; c++) due[c] <= 0;
    end else begin
      for (int c = 0; c < N_CHAN; c++) begin
        if (due[c] == 1) begin
          nco_dv_out   <= 1'b1;
          nco_chan_ret <= CW'(c);
          nco_q        <= chip_pat[c];
        end
        due[c] <= (due[c] > 0) ? due[c] - 1 : 0;
      end
      if (nco_dv_in && !drop_mask[nco_chan]) due[nco_chan] <= lat_tab[nco_chan];
    end
  end

  // Per-sample observation filled in by step_sample.
  int          n_dvin, dvin_first, dvin_last;
  logic [31:0] freq_seen [N_CHAN];
  logic [5:0]  ca_seen   [N_CHAN];

  task automatic step_sample(input int budget, output int n, output bit ok);
    n_dvin = 0; dvin_first = -1; dvin_last = -1; n = 0; ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (nco_dv_in) begin
        n_dvin++;
        if (dvin_first < 0) dvin_first = i;
        dvin_last = i;
        freq_seen[nco_chan] = nco_freq;
        ca_seen[nco_chan]   = nco_ca_sel;
      end
      if (code_dv) begin
        n  = i + 1;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_slot(input int ch, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (nco_dv_in && nco_chan == CW'(ch)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic cfg_write(input int ch, input logic [31:0] f, input logic [5:0] ca,
                           input logic en);
    cfg_we = 1'b1; cfg_chan = CW'(ch); cfg_freq = f; cfg_ca_sel = ca; cfg_en = en;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic pulse_commit();
    cfg_commit = 1'b1;
    @(negedge clk);
    cfg_commit = 1'b0;
  endtask

  task automatic test_reset();
    int dv_cnt, pub_cnt;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy_in_reset: got %b want 0", busy); end
    reset_n = 1'b1;
    dv_cnt = 0; pub_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (nco_dv_in) dv_cnt++;
      if (code_dv)   pub_cnt++;
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_checks++; if (dv_cnt != 0) begin n_fail++; $display("FAIL rst_dv_in: got %0d want 0", dv_cnt); end
    n_checks++; if (pub_cnt != 0) begin n_fail++; $display("FAIL rst_code_dv: got %0d want 0", pub_cnt); end
    n_checks++; if (code_mask !== 8'h00 || code_bits !== 8'h00) begin n_fail++; $display("FAIL rst_code: got mask %h bits %h want 00 00", code_mask, code_bits); end
    n_checks++; if (err_timeout !== 1'b0 || commit_pend !== 1'b0) begin n_fail++; $display("FAIL rst_flags: got err %b pend %b want 0 0", err_timeout, commit_pend); end
    n_checks++; if (nco_chan !== '0 || nco_freq !== '0 || nco_ca_sel !== '0) begin n_fail++; $display("FAIL rst_nco_bus: got %h %h %h want 0", nco_chan, nco_freq, nco_ca_sel); end
  endtask

  task automatic test_single_chan();
    int n; bit ok;
    cfg_write(3, 32'h27456789, 6'd3, 1'b1);
    pulse_commit();
    n_checks++; if (commit_pend !== 1'b1) begin n_fail++; $display("FAIL single_pend_set: got %b want 1", commit_pend); end
    run = 1'b1;
    step_sample(200, n, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL single_code_dv: got none want code_dv"); end
    n_checks++; if (dvin_first != 4) begin n_fail++; $display("FAIL single_dvin_offset: got %0d want 4", dvin_first); end
    n_checks++; if (n_dvin != 1) begin n_fail++; $display("FAIL single_dvin_count: got %0d want 1", n_dvin); end
    n_checks++; if (freq_seen[3] !== 32'h27456789 || ca_seen[3] !== 6'd3) begin n_fail++; $display("FAIL single_nco_cfg: got %h/%0d want 27456789/3", freq_seen[3], ca_seen[3]); end
    n_checks++; if (code_mask !== 8'h08 || code_bits !== 8'h08) begin n_fail++; $display("FAIL single_code: got mask %h bits %h want 08 08", code_mask, code_bits); end
    n_checks++; if (commit_pend !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL single_flags: got pend %b busy %b want 0 1", commit_pend, busy); end
    step_sample(200, n, ok);
    n_checks++; if (!ok || n != 64) begin n_fail++; $display("FAIL single_period: got %0d want 64", n); end
    n_checks++; if (n_dvin != 1 || code_mask !== 8'h08) begin n_fail++; $display("FAIL single_second: got dvin %0d mask %h want 1 08", n_dvin, code_mask); end
  endtask

  task automatic test_all_chan();
    int n; bit ok;
    for (int c = 0; c < N_CHAN; c++) cfg_write(c, 32'h1000_0000 + c, 6'(c + 1), 1'b1);
    pulse_commit();
    step_sample(200, n, ok);
    n_checks++; if (!ok || n_dvin != 8) begin n_fail++; $display("FAIL all_dvin_count: got %0d want 8", n_dvin); end
    n_checks++; if (dvin_last - dvin_first != 7) begin n_fail++; $display("FAIL all_dvin_consecutive: got span %0d want 7", dvin_last - dvin_first); end
    n_checks++; if (code_mask !== 8'hFF || code_bits !== 8'hC9) begin n_fail++; $display("FAIL all_code: got mask %h bits %h want FF C9", code_mask, code_bits); end
    n_checks++; if (freq_seen[5] !== 32'h1000_0005 || ca_seen[7] !== 6'd8) begin n_fail++; $display("FAIL all_nco_cfg: got %h/%0d want 10000005/8", freq_seen[5], ca_seen[7]); end
    n_checks++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL all_err: got %b want 0", err_timeout); end
    chip_pat = 8'h36;
    step_sample(200, n, ok);
    n_checks++; if (!ok || n != 64) begin n_fail++; $display("FAIL all_period: got %0d want 64", n); end
    n_checks++; if (code_mask !== 8'hFF || code_bits !== 8'h36) begin n_fail++; $display("FAIL all_code2: got mask %h bits %h want FF 36", code_mask, code_bits); end
  endtask

  task automatic test_staged_update();
    int n; bit ok;
    wait_slot(0, 200, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL staged_slot0: got none want slot 0 strobe"); end
    cfg_write(3, 32'h12468ace, 6'd9, 1'b1);
    pulse_commit();
    n_checks++; if (commit_pend !== 1'b1) begin n_fail++; $display("FAIL staged_pend_set: got %b want 1", commit_pend); end
    step_sample(200, n, ok);
    n_checks++; if (freq_seen[3] !== 32'h1000_0003 || ca_seen[3] !== 6'd4) begin n_fail++; $display("FAIL staged_old_cfg: got %h/%0d want 10000003/4", freq_seen[3], ca_seen[3]); end
    n_checks++; if (commit_pend !== 1'b1) begin n_fail++; $display("FAIL staged_pend_hold: got %b want 1", commit_pend); end
    step_sample(200, n, ok);
    n_checks++; if (freq_seen[3] !== 32'h12468ace || ca_seen[3] !== 6'd9) begin n_fail++; $display("FAIL staged_new_cfg: got %h/%0d want 12468ace/9", freq_seen[3], ca_seen[3]); end
    n_checks++; if (commit_pend !== 1'b0) begin n_fail++; $display("FAIL staged_pend_clear: got %b want 0", commit_pend); end
    n_checks++; if (!ok || n != 64) begin n_fail++; $display("FAIL staged_period: got %0d want 64", n); end
  endtask

  task automatic test_timeout();
    int n; bit ok;
    drop_mask = 8'h20;
    step_sample(200, n, ok);
    n_checks++; if (!ok || err_timeout !== 1'b1) begin n_fail++; $display("FAIL to_err_set: got %b want 1", err_timeout); end
    n_checks++; if (code_mask !== 8'hDF || code_bits !== 8'h16) begin n_fail++; $display("FAIL to_code: got mask %h bits %h want DF 16", code_mask, code_bits); end
    step_sample(200, n, ok);
    n_checks++; if (!ok || n != 64) begin n_fail++; $display("FAIL to_period: got %0d want 64", n); end
    n_checks++; if (code_mask !== 8'hDF) begin n_fail++; $display("FAIL to_mask2: got %h want DF", code_mask); end
    drop_mask = 8'h00;
    step_sample(200, n, ok);
    n_checks++; if (code_mask !== 8'hFF || code_bits !== 8'h36) begin n_fail++; $display("FAIL to_recover: got mask %h bits %h want FF 36", code_mask, code_bits); end
    n_checks++; if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b want 1", err_timeout); end
  endtask

  task automatic test_stop_and_abort();
    int n, dv_cnt, pub_cnt; bit ok;
    wait_slot(2, 200, ok);
    run = 1'b0;
    step_sample(200, n, ok);
    n_checks++; if (!ok || code_mask !== 8'hFF) begin n_fail++; $display("FAIL stop_last_sample: got ok %b mask %h want 1 FF", ok, code_mask); end
    dv_cnt = 0; pub_cnt = 0;
    repeat (80) begin
      @(negedge clk);
      if (nco_dv_in) dv_cnt++;
      if (code_dv)   pub_cnt++;
    end
    n_checks++; if (busy !== 1'b0 || dv_cnt != 0 || pub_cnt != 0) begin n_fail++; $display("FAIL stop_idle: got busy %b dvin %0d code_dv %0d want 0 0 0", busy, dv_cnt, pub_cnt); end
    run = 1'b1;
    wait_slot(2, 200, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL abort_slot2: got none want slot 2 strobe"); end
    reset_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || nco_dv_in !== 1'b0 || code_dv !== 1'b0) begin n_fail++; $display("FAIL abort_ctrl: got busy %b dvin %b code_dv %b want 0 0 0", busy, nco_dv_in, code_dv); end
    n_checks++; if (code_mask !== 8'h00 || err_timeout !== 1'b0 || commit_pend !== 1'b0) begin n_fail++; $display("FAIL abort_state: got mask %h err %b pend %b want 00 0 0", code_mask, err_timeout, commit_pend); end
    run = 1'b0;
    pub_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (code_dv) pub_cnt++;
    end
    reset_n = 1'b1;
    run = 1'b1;
    step_sample(200, n, ok);
    n_checks++; if (pub_cnt != 0) begin n_fail++; $display("FAIL abort_no_code_dv: got %0d want 0", pub_cnt); end
    n_checks++; if (!ok || n_dvin != 0 || code_mask !== 8'h00) begin n_fail++; $display("FAIL abort_tables_cleared: got dvin %0d mask %h want 0 00", n_dvin, code_mask); end
    run = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_chan();
    test_all_chan();
    test_staged_update();
    test_timeout();
    test_stop_and_abort();
    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
